// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported, byte-masked data memory between the
// core load/store path (port 0) and a loader/debug DMA path (port 1).
// Round-robin arbitration, optional bounded burst lock for port 1, and load
// data returned to the granted port one cycle after the handshake.
module dmem_arbiter #(
    parameter int AW        = 16,
    parameter int BURST_MAX = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req0_valid,
    output logic          o_req0_ready,
    input  logic [AW-1:0] i_req0_addr,
    input  logic [31:0]   i_req0_wdata,
    input  logic [3:0]    i_req0_bmask,
    input  logic          i_req0_wren,
    output logic          o_req0_rvalid,
    output logic [31:0]   o_req0_rdata,
    input  logic          i_req1_valid,
    output logic          o_req1_ready,
    input  logic [AW-1:0] i_req1_addr,
    input  logic [31:0]   i_req1_wdata,
    input  logic [3:0]    i_req1_bmask,
    input  logic          i_req1_wren,
    input  logic          i_req1_lock,
    output logic          o_req1_rvalid,
    output logic [31:0]   o_req1_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic [3:0]    o_mem_bmask,
    output logic          o_mem_wren,
    output logic          o_mem_rden,
    input  logic [31:0]   i_mem_rdata
);
    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    lock_state_t state_q, state_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        pend_q, pend_d;
    logic        pend_port_q, pend_port_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        rr_grant0_s, rr_grant1_s;
    logic        grant0_s, grant1_s, grant_s;
    logic        sel_wren_s;
    logic        ret0_s, ret1_s;

    // Plain round-robin choice: on contention the port not granted last wins.
    always_comb begin
        rr_grant0_s = 1'b0;
        rr_grant1_s = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            rr_grant0_s = last_grant_q;
            rr_grant1_s = ~last_grant_q;
        end else begin
            rr_grant0_s = i_req0_valid;
            rr_grant1_s = i_req1_valid;
        end
    end

    // Final grant: a locked port 1 preempts round-robin until port 0 has seen BURST_MAX of its grants.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (i_reset) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else begin
            case (state_q)
                ST_LOCKED: begin
                    if (i_req0_valid && (burst_cnt_q == BURST_LIM)) begin
                        grant0_s = 1'b1;
                    end else if (i_req1_valid && i_req1_lock) begin
                        grant1_s = 1'b1;
                    end else begin
                        grant0_s = rr_grant0_s;
                        grant1_s = rr_grant1_s;
                    end
                end
                ST_UNLOCKED: begin
                    grant0_s = rr_grant0_s;
                    grant1_s = rr_grant1_s;
                end
                default: begin
                    grant0_s = rr_grant0_s;
                    grant1_s = rr_grant1_s;
                end
            endcase
        end
    end

    assign grant_s = grant0_s | grant1_s;

    // Lock FSM next state, saturating burst counter and last-grant tracking.
    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = 8'd0;
        last_grant_d = last_grant_q;
        if (grant_s) begin
            last_grant_d = grant1_s;
        end else begin
            last_grant_d = last_grant_q;
        end
        case (state_q)
            ST_UNLOCKED: begin
                if (grant1_s && i_req1_lock) begin
                    state_d     = ST_LOCKED;
                    burst_cnt_d = i_req0_valid ? 8'd1 : 8'd0;
                end else begin
                    state_d     = ST_UNLOCKED;
                    burst_cnt_d = 8'd0;
                end
            end
            ST_LOCKED: begin
                if (grant1_s && i_req1_lock) begin
                    state_d = ST_LOCKED;
                    if (!i_req0_valid) begin
                        burst_cnt_d = 8'd0;
                    end else if (burst_cnt_q < BURST_LIM) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end else begin
                        burst_cnt_d = burst_cnt_q;
                    end
                end else begin
                    state_d     = ST_UNLOCKED;
                    burst_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d     = ST_UNLOCKED;
                burst_cnt_d = 8'd0;
            end
        endcase
    end

    // Memory command mux: follows the granted port, all zero when idle.
    always_comb begin
        o_mem_addr  = {AW{1'b0}};
        o_mem_wdata = 32'h0000_0000;
        o_mem_bmask = 4'b0000;
        sel_wren_s  = 1'b0;
        if (grant0_s) begin
            o_mem_addr  = i_req0_addr;
            o_mem_wdata = i_req0_wdata;
            o_mem_bmask = i_req0_bmask;
            sel_wren_s  = i_req0_wren;
        end else if (grant1_s) begin
            o_mem_addr  = i_req1_addr;
            o_mem_wdata = i_req1_wdata;
            o_mem_bmask = i_req1_bmask;
            sel_wren_s  = i_req1_wren;
        end else begin
            o_mem_addr  = {AW{1'b0}};
            o_mem_wdata = 32'h0000_0000;
            o_mem_bmask = 4'b0000;
            sel_wren_s  = 1'b0;
        end
    end

    // A zero-mask store still takes its slot but must not strobe the macro.
    assign o_mem_wren = sel_wren_s && (o_mem_bmask != 4'b0000);
    assign o_mem_rden = grant_s && !sel_wren_s;

    assign ret0_s = pend_q && !pend_port_q;
    assign ret1_s = pend_q && pend_port_q;

    // Read-return bookkeeping: remember who issued the load, keep last data per port.
    always_comb begin
        pend_d      = o_mem_rden;
        pend_port_d = grant1_s;
        if (ret0_s) begin
            rdata0_d = i_mem_rdata;
        end else begin
            rdata0_d = rdata0_q;
        end
        if (ret1_s) begin
            rdata1_d = i_mem_rdata;
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // State registers with synchronous reset; reset drops any in-flight read.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_UNLOCKED;
            burst_cnt_q  <= 8'd0;
            last_grant_q <= 1'b1;
            pend_q       <= 1'b0;
            pend_port_q  <= 1'b0;
            rdata0_q     <= 32'h0000_0000;
            rdata1_q     <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_grant_q <= last_grant_d;
            pend_q       <= pend_d;
            pend_port_q  <= pend_port_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign o_req0_ready  = grant0_s;
    assign o_req1_ready  = grant1_s;
    assign o_req0_rvalid = ret0_s && !i_reset;
    assign o_req1_rvalid = ret1_s && !i_reset;
    assign o_req0_rdata  = i_reset ? 32'h0000_0000 : (ret0_s ? i_mem_rdata : rdata0_q);
    assign o_req1_rdata  = i_reset ? 32'h0000_0000 : (ret1_s ? i_mem_rdata : rdata1_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized stimulus against a behavioural
// model; load responses are checked by a separate scoreboard monitor.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int AW = 16;
    localparam int BM = 4;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_req0_valid, i_req1_valid, i_req1_lock;
    logic          o_req0_ready, o_req1_ready;
    logic [AW-1:0] i_req0_addr, i_req1_addr;
    logic [31:0]   i_req0_wdata, i_req1_wdata;
    logic [3:0]    i_req0_bmask, i_req1_bmask;
    logic          i_req0_wren, i_req1_wren;
    logic          o_req0_rvalid, o_req1_rvalid;
    logic [31:0]   o_req0_rdata, o_req1_rdata;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [3:0]    o_mem_bmask;
    logic          o_mem_wren, o_mem_rden;
    logic [31:0]   i_mem_rdata = 32'h0;

    dmem_arbiter #(.AW(AW), .BURST_MAX(BM)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_addr(i_req0_addr), .i_req0_wdata(i_req0_wdata),
        .i_req0_bmask(i_req0_bmask), .i_req0_wren(i_req0_wren),
        .o_req0_rvalid(o_req0_rvalid), .o_req0_rdata(o_req0_rdata),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_addr(i_req1_addr), .i_req1_wdata(i_req1_wdata),
        .i_req1_bmask(i_req1_bmask), .i_req1_wren(i_req1_wren),
        .i_req1_lock(i_req1_lock),
        .o_req1_rvalid(o_req1_rvalid), .o_req1_rdata(o_req1_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren),
        .o_mem_rden(o_mem_rden), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Memory macro: byte-masked write at the edge, read data valid the next cycle.
    logic [31:0] mem [0:255];
    always @(posedge i_clk) begin
        if (o_mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (o_mem_bmask[b]) mem[o_mem_addr[9:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
        end
        if (o_mem_rden) i_mem_rdata <= mem[o_mem_addr[9:2]];
    end

    function automatic logic [31:0] pat(int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural reference: expected memory plus arbitration rules.
    logic [31:0] ref_mem [0:255];
    bit m_locked;   // port 1 owns the memory under lock
    int m_starve;   // locked port-1 grants taken while port 0 was waiting
    bit m_last;     // port that received the most recent grant
    bit g0, g1;     // model grants for the current cycle

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic predict_check();
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wd;
        logic [3:0]    e_bm;
        logic          e_we, e_re;
        g0 = 1'b0; g1 = 1'b0;
        if (!i_reset) begin
            if (m_locked && i_req0_valid && m_starve >= BM) g0 = 1'b1;
            else if (m_locked && i_req1_valid && i_req1_lock) g1 = 1'b1;
            else if (i_req0_valid && i_req1_valid) begin g0 = m_last; g1 = !m_last; end
            else begin g0 = i_req0_valid; g1 = i_req1_valid; end
        end
        e_addr = '0; e_wd = 32'h0; e_bm = 4'h0; e_we = 1'b0; e_re = 1'b0;
        if (g0) begin
            e_addr = i_req0_addr; e_wd = i_req0_wdata; e_bm = i_req0_bmask;
            e_we = i_req0_wren && (i_req0_bmask != 4'h0); e_re = !i_req0_wren;
        end else if (g1) begin
            e_addr = i_req1_addr; e_wd = i_req1_wdata; e_bm = i_req1_bmask;
            e_we = i_req1_wren && (i_req1_bmask != 4'h0); e_re = !i_req1_wren;
        end
        check("grant", {o_req1_ready, o_req0_ready}, {g1, g0});
        check("memcmd", {o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren, o_mem_rden},
              {e_addr, e_wd, e_bm, e_we, e_re});
        if (i_reset) begin
            m_locked = 1'b0; m_starve = 0; m_last = 1'b1;
        end else begin
            if (e_re) exp_q.push_back('{due: cyc + 1, port: g1, data: ref_mem[e_addr[9:2]]});
            if (e_we) begin
                for (int b = 0; b < 4; b++)
                    if (e_bm[b]) ref_mem[e_addr[9:2]][8*b +: 8] = e_wd[8*b +: 8];
            end
            if (g0 || g1) m_last = g1;
            if (i_req0_valid && g1 && i_req1_lock) m_starve = (m_starve + 1 > BM) ? BM : m_starve + 1;
            else m_starve = 0;
            m_locked = g1 && i_req1_lock;
        end
    endtask

    // Scoreboard monitor: every rvalid must match the oldest outstanding load.
    logic [31:0] last0 = 32'h0, last1 = 32'h0;
    always @(negedge i_clk) begin
        if (i_reset) begin
            check("reset_rsp", {o_req1_rvalid, o_req0_rvalid, o_req1_rdata, o_req0_rdata}, 64'h0);
            exp_q.delete();
            last0 = 32'h0; last1 = 32'h0;
        end else begin
            if (o_req0_rvalid || o_req1_rvalid) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_spurious", {o_req1_rvalid, o_req0_rvalid}, 2'b00);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_port", {o_req1_rvalid, o_req0_rvalid}, mon_e.port ? 2'b10 : 2'b01);
                    check("rsp_time", cyc, mon_e.due);
                    check("rsp_data", mon_e.port ? o_req1_rdata : o_req0_rdata, mon_e.data);
                    if (mon_e.port) last1 = mon_e.data;
                    else last0 = mon_e.data;
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                check("rsp_missing", {o_req1_rvalid, o_req0_rvalid}, exp_q[0].port ? 2'b10 : 2'b01);
                void'(exp_q.pop_front());
            end
            if (!o_req0_rvalid) check("rdata0_hold", o_req0_rdata, last0);
            if (!o_req1_rvalid) check("rdata1_hold", o_req1_rdata, last1);
        end
    end

    // Per-cycle samples for directed checks.
    logic        s_rdy0, s_rdy1, s_rv0, s_rv1, s_wren, s_any;
    logic [31:0] s_rd0, s_rd1;

    task automatic tick();
        @(negedge i_clk);
        s_rdy0 = o_req0_ready; s_rdy1 = o_req1_ready;
        s_rv0 = o_req0_rvalid; s_rv1 = o_req1_rvalid;
        s_rd0 = o_req0_rdata; s_rd1 = o_req1_rdata; s_wren = o_mem_wren;
        s_any = |{o_req0_ready, o_req1_ready, o_req0_rvalid, o_req1_rvalid, o_req0_rdata,
                  o_req1_rdata, o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren, o_mem_rden};
        predict_check();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set0(logic v, logic [AW-1:0] a, logic [31:0] d, logic [3:0] m, logic w);
        i_req0_valid = v; i_req0_addr = a; i_req0_wdata = d; i_req0_bmask = m; i_req0_wren = w;
    endtask

    task automatic set1(logic v, logic [AW-1:0] a, logic [31:0] d, logic [3:0] m, logic w, logic l);
        i_req1_valid = v; i_req1_addr = a; i_req1_wdata = d; i_req1_bmask = m; i_req1_wren = w;
        i_req1_lock = l;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got0;
        for (int i = 0; i < 256; i++) begin mem[i] = pat(i); ref_mem[i] = pat(i); end
        m_locked = 1'b0; m_starve = 0; m_last = 1'b1;
        i_reset = 1'b1;
        set0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
        set1(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        @(posedge i_clk); #1;
        tick(); tick();
        check("reset_outputs", s_any, 1'b0);
        i_reset = 1'b0;

        // Single port store then load.
        set0(1'b1, 16'h0020, 32'hDEAD_BEEF, 4'b1111, 1'b1);
        tick(); check("single_store_ready", s_rdy0, 1'b1);
        set0(1'b1, 16'h0020, 32'h0, 4'b1111, 1'b0);
        tick(); check("single_load_ready", s_rdy0, 1'b1);
        set0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
        tick(); check("single_load_rsp", {s_rv0, s_rd0}, {1'b1, 32'hDEAD_BEEF});

        // Reset while a load is in flight.
        set0(1'b1, 16'h0010, 32'h0, 4'hF, 1'b0);
        tick(); check("midread_ready", s_rdy0, 1'b1);
        set0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
        i_reset = 1'b1;
        tick(); check("midread_rvalid", s_rv0, 1'b0); check("midread_all_zero", s_any, 1'b0);
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin tick(); check("post_reset_rvalid", {s_rv1, s_rv0}, 2'b00); end

        // Contention round-robin starting with port 0.
        set0(1'b1, 16'h0004, 32'h0, 4'hF, 1'b0);
        set1(1'b1, 16'h0008, 32'h0, 4'hF, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(); check("rr_grant", {s_rdy1, s_rdy0}, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        set0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
        set1(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        tick(); tick();

        // Burst lock bounded by BM grants while port 0 waits.
        set1(1'b1, 16'h000C, 32'h0, 4'hF, 1'b0, 1'b1);
        tick(); tick();
        set0(1'b1, 16'h0004, 32'h0, 4'hF, 1'b0);
        n = 0; got0 = 1'b0;
        for (int k = 0; k < 12 && !got0; k++) begin
            tick();
            if (s_rdy1) n++;
            if (s_rdy0) got0 = 1'b1;
        end
        check("burst_p1_grants", n, BM);
        check("burst_p0_granted", got0, 1'b1);
        set0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);

        // Lock release hands over to waiting port 0 at once.
        tick(); check("relock_p1", s_rdy1, 1'b1);
        set0(1'b1, 16'h0004, 32'h0, 4'hF, 1'b0);
        tick(); check("locked_p1_wins", s_rdy1, 1'b1);
        i_req1_lock = 1'b0;
        tick(); check("release_p0", s_rdy0, 1'b1);
        set0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
        set1(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        tick();

        // Zero-mask store leaves memory untouched.
        set1(1'b1, 16'h0030, 32'h1234_5678, 4'b0000, 1'b1, 1'b0);
        tick(); check("zmask_ready", s_rdy1, 1'b1); check("zmask_wren", s_wren, 1'b0);
        set1(1'b1, 16'h0030, 32'h0, 4'hF, 1'b0, 1'b0);
        tick();
        set1(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        tick(); check("zmask_readback", {s_rv1, s_rd1}, {1'b1, pat(12)});

        // Randomized traffic; a requester holds its command until accepted.
        for (int k = 0; k < 2000; k++) begin
            i_reset = ($urandom_range(0, 149) == 0);
            if (!(i_req0_valid && !g0))
                set0(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 15) * 4), $urandom,
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if (!(i_req1_valid && !g1))
                set1(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 15) * 4), $urandom,
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), i_req1_lock);
            i_req1_lock = ($urandom_range(0, 3) != 0);
            tick();
        end
        i_reset = 1'b0;
        set0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
        set1(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        check("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter placed in front of the data memory macro. It shares one single-ported, byte-masked data memory between two requesters: the core load/store path (port 0) and a loader/debug DMA path (port 1). It performs round-robin arbitration with an optional bounded burst lock for port 1. It returns read data to the granted port one cycle after issue.

## Interface
Parameters:
- AW, 16: memory byte-address width.
- BURST_MAX, 8: maximum consecutive port-1 grants under lock while port 0 waits (1..255).

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req0_valid / i_req1_valid  in  1  request valid.
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle (grant).
- i_reqN_addr  in  AW  byte address.
- i_reqN_wdata  in  32  store data, already lane-aligned.
- i_reqN_bmask  in  4  byte-lane mask.
- i_reqN_wren  in  1  1 = store, 0 = load.
- i_req1_lock  in  1  port 1 requests back-to-back ownership.
- o_reqN_rvalid  out  1  load data valid for port N.
- o_reqN_rdata  out  32  load data.
- o_mem_addr  out  AW  memory address.
- o_mem_wdata  out  32  memory write data.
- o_mem_bmask  out  4  memory byte mask.
- o_mem_wren  out  1  memory write strobe.
- o_mem_rden  out  1  memory read strobe.
- i_mem_rdata  in  32  memory read data, valid the cycle after o_mem_rden.

## Operation
- Grant is combinational from the valid inputs and registered state. The memory command outputs are driven combinationally from the granted port; they are all zero when no grant is made.
- A handshake completes on the cycle when valid and ready are both high. A requester holds addr/wdata/bmask/wren stable while valid is high and ready is low.
- At most one port is ready per cycle.
- A store with bmask == 0 is granted and consumes a slot, but drives o_mem_wren = 0.
- Round-robin uses the last_grant register, reset to 1 so that port 0 wins the first contention. When both ports are valid, the port not equal to last_grant wins. last_grant updates on every grant.
- Lock FSM states: UNLOCKED and LOCKED.
  - UNLOCKED -> LOCKED when port 1 is granted with i_req1_lock = 1. burst_cnt loads 1.
  - While LOCKED, port 1 has absolute priority if it is valid with lock = 1. Each such grant increments burst_cnt while port 0 is valid. burst_cnt resets to 0 on any cycle where port 0 is not valid.
  - When burst_cnt == BURST_MAX and port 0 is valid, the next grant goes to port 0 and the FSM moves to UNLOCKED.
  - LOCKED -> UNLOCKED also occurs when port 1 drops valid or drops lock; ordinary round-robin applies that cycle.
- Read return: a 1-bit pending register and a pending-port register capture the load grant. On the next cycle, o_reqP_rvalid = 1 and o_reqP_rdata = i_mem_rdata. The other port's rvalid stays 0 and its rdata holds its last value.
- Reads are fully pipelined. A new grant is allowed in the same cycle as a read return.
- Stores produce no rvalid.

## Timing
- Reset values:
  - All ready outputs, rvalid outputs, o_mem_wren and o_mem_rden are 0 while i_reset = 1.
  - o_reqN_rdata is 0.
  - The pending register is 0, so any in-flight read is dropped and no rvalid appears after reset.
  - FSM is UNLOCKED, burst_cnt is 0, last_grant is 1.
- Grant latency: 0 cycles when uncontended. Worst-case wait for port 0 is BURST_MAX cycles. Worst-case wait for port 1 is 1 cycle.
- Load latency: rvalid occurs exactly 1 cycle after the handshake.
- Store takes effect at the clock edge of the handshake cycle.
- A store to address A followed by a load from A in the next cycle returns the stored data. This is the memory macro's write-then-read order; the arbiter adds no forwarding.
- burst_cnt saturates at BURST_MAX and never wraps.

## Test plan
- Reset mid-read: port 0 loads addr 0x0010, and i_reset is asserted the next cycle. Required: o_req0_rvalid = 0, all outputs are 0, and no rvalid appears afterwards.
- Single port: port 0 stores 0xDEADBEEF with bmask 4'b1111 to 0x0020, then loads 0x0020. Required: ready in the same cycle as valid, and o_req0_rdata = 0xDEADBEEF with rvalid 1 cycle after the load handshake.
- Contention round-robin: both ports are continuously valid with loads and no lock. Required: grants alternate 0, 1, 0, 1 starting with port 0. Each rvalid arrives on the matching port with the correct data.
- Burst lock: BURST_MAX = 4, port 1 is locked and continuously valid, and port 0 becomes valid. Required: port 1 receives exactly 4 grants, then port 0 is granted. The FSM returns to UNLOCKED.
- Lock release: port 1 is locked and drops i_req1_lock while port 0 waits. Required: port 0 is granted on the next cycle.
- Zero mask: port 1 stores with bmask 4'b0000. Required: ready = 1, o_mem_wren = 0, and the memory contents are unchanged on readback.
